// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
//
// Command-driven controller for the loadable W-bit up-counter. Opcodes arrive
// over a valid/ready handshake. The controller drives the counter's enable,
// load and load value. It also watches the counter output for a programmable
// terminal value, so it can run one-shot or periodic count windows.
//
// Optional feature macro: COUNTER_SEQUENCER_IRQ_EN
//   When defined, it adds the irq_clr input and a sticky irq output. irq is
//   set by every done pulse and cleared by irq_clr. If both happen in the same
//   cycle, set wins.
//
// Ports:
//   clk          in   1       system clock, rising edge
//   rst          in   1       synchronous active-high reset
//   cmd_valid    in   1       command present
//   cmd_ready    out  1       command can be accepted this cycle (0 only in ARM)
//   cmd_op       in   3       0 NOP, 1 LOAD, 2 SET_TERM, 3 START_ONESHOT,
//                             4 START_PERIODIC, 5 PAUSE, 6 RESUME, 7 STOP
//   cmd_arg      in   W       operand for LOAD / SET_TERM
//   cnt_value    in   W       current counter output
//   cnt_en       out  1       counter increment enable
//   cnt_load     out  1       counter synchronous load (wins over enable)
//   cnt_load_val out  W       value loaded when cnt_load=1 (always start_val)
//   busy         out  1       high in ARM, RUN or PAUSED
//   done         out  1       one-cycle pulse on terminal match in RUN
//   period_cnt   out  PCNT_W  completed windows since last start, saturating
//   irq_clr      in   1       (IRQ_EN only) clear sticky interrupt
//   irq          out  1       (IRQ_EN only) sticky done interrupt
// -----------------------------------------------------------------------------
module counter_sequencer #(
    parameter int W      = 8,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [W-1:0]      cmd_arg,
    input  logic [W-1:0]      cnt_value,
    output logic              cnt_en,
    output logic              cnt_load,
    output logic [W-1:0]      cnt_load_val,
    output logic              busy,
    output logic              done,
    output logic [PCNT_W-1:0] period_cnt
`ifdef COUNTER_SEQUENCER_IRQ_EN
    ,
    input  logic              irq_clr,
    output logic              irq
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP            = 3'd0,
        OP_LOAD           = 3'd1,
        OP_SET_TERM       = 3'd2,
        OP_START_ONESHOT  = 3'd3,
        OP_START_PERIODIC = 3'd4,
        OP_PAUSE          = 3'd5,
        OP_RESUME         = 3'd6,
        OP_STOP           = 3'd7
    } op_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [W-1:0]        r_startVal;
    logic [W-1:0]        r_term;
    logic                r_mode;
    logic [PCNT_W-1:0]   r_periodCnt;

    op_t                 w_op;
    logic                w_accept;
    logic                w_isStart;
    logic                w_startTaken;
    logic                w_match;

    // Decode the handshake. Only ARM refuses commands. A start opcode has an
    // effect only in the idle-like states (and PAUSED); RUN ignores it.
    assign w_op         = op_t'(cmd_op);
    assign cmd_ready    = (r_state != ARM);
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_isStart    = (w_op == OP_START_ONESHOT) || (w_op == OP_START_PERIODIC);
    assign w_startTaken = w_accept && w_isStart &&
                          ((r_state == IDLE) || (r_state == DONE) || (r_state == PAUSED));
    assign w_match      = (r_state == RUN) && (cnt_value == r_term);

    // The state register simply follows the next-state decode. A reset drops
    // whatever command is pending and returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode. The terminal-match outcome is worked out first, so a
    // command accepted in the same cycle overrides it. The match side effects
    // (done, load, period count) still happen that cycle, because they are
    // decoded separately below.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    if (w_isStart) begin
                        w_nextState = ARM;
                    end else if (w_op == OP_STOP) begin
                        w_nextState = IDLE;
                    end
                end
            end
            ARM: begin
                w_nextState = RUN;
            end
            RUN: begin
                if (w_match && !r_mode) begin
                    w_nextState = DONE;
                end
                if (w_accept) begin
                    if (w_op == OP_PAUSE) begin
                        w_nextState = PAUSED;
                    end else if (w_op == OP_STOP) begin
                        w_nextState = IDLE;
                    end
                end
            end
            PAUSED: begin
                if (w_accept) begin
                    if (w_op == OP_RESUME) begin
                        w_nextState = RUN;
                    end else if (w_isStart) begin
                        w_nextState = ARM;
                    end else if (w_op == OP_STOP) begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Counter-facing outputs. ARM preloads start_val. RUN counts until the
    // match cycle. In that cycle periodic mode reloads start_val, so the window
    // wraps, and one-shot mode just stops enabling. The load value is always
    // start_val, so it needs no mux.
    always_comb begin
        cnt_en       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = r_startVal;
        done         = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ARM: begin
                cnt_load = 1'b1;
                busy     = 1'b1;
            end
            RUN: begin
                busy     = 1'b1;
                cnt_en   = !w_match;
                done     = w_match;
                cnt_load = w_match && r_mode;
            end
            PAUSED: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Configuration and window bookkeeping. LOAD and SET_TERM act in any
    // state that accepts commands. A taken start latches the mode and restarts
    // the window count. The period counter sticks at all-ones rather than
    // wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_startVal  <= '0;
            r_term      <= '1;
            r_mode      <= 1'b0;
            r_periodCnt <= '0;
        end else begin
            if (w_accept && (w_op == OP_LOAD)) begin
                r_startVal <= cmd_arg;
            end
            if (w_accept && (w_op == OP_SET_TERM)) begin
                r_term <= cmd_arg;
            end
            if (w_startTaken) begin
                r_mode      <= (w_op == OP_START_PERIODIC);
                r_periodCnt <= '0;
            end else if (w_match && (r_periodCnt != '1)) begin
                r_periodCnt <= r_periodCnt + PCNT_W'(1);
            end
        end
    end

    assign period_cnt = r_periodCnt;

`ifdef COUNTER_SEQUENCER_IRQ_EN
    logic r_irq;

    // The interrupt is sticky. A done pulse in the same cycle as irq_clr must
    // leave it set, so the set branch is tested first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (w_match) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_sequencer
//
// Bench for counter_sequencer. It contains a behavioural model of the loadable
// up-counter, so cnt_value closes the loop the same way the real counter does.
// Each window that is started pushes its expected done events into a queue:
// the cycle, the counter value and the pre-increment period count. A monitor
// pops an entry on every done pulse. Directed checks cover the handshake,
// pause/resume, reset and the optional irq.
// -----------------------------------------------------------------------------
module tb_counter_sequencer;

    localparam int W      = 8;
    localparam int PCNT_W = 8;

    localparam logic [2:0] OP_NOP            = 3'd0;
    localparam logic [2:0] OP_LOAD           = 3'd1;
    localparam logic [2:0] OP_SET_TERM       = 3'd2;
    localparam logic [2:0] OP_START_ONESHOT  = 3'd3;
    localparam logic [2:0] OP_START_PERIODIC = 3'd4;
    localparam logic [2:0] OP_PAUSE          = 3'd5;
    localparam logic [2:0] OP_RESUME         = 3'd6;
    localparam logic [2:0] OP_STOP           = 3'd7;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmdValid;
    logic              cmdReady;
    logic [2:0]        cmdOp;
    logic [W-1:0]      cmdArg;
    logic [W-1:0]      cntValue;
    logic              cntEn;
    logic              cntLoad;
    logic [W-1:0]      cntLoadVal;
    logic              busy;
    logic              done;
    logic [PCNT_W-1:0] periodCnt;
`ifdef COUNTER_SEQUENCER_IRQ_EN
    logic              irqClr;
    logic              irq;
`endif

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int                cycle;
        logic [W-1:0]      value;
        logic [PCNT_W-1:0] pcnt;
    } expEntry_t;

    expEntry_t expQ[$];

    counter_sequencer #(.W(W), .PCNT_W(PCNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmdValid),
        .cmd_ready    (cmdReady),
        .cmd_op       (cmdOp),
        .cmd_arg      (cmdArg),
        .cnt_value    (cntValue),
        .cnt_en       (cntEn),
        .cnt_load     (cntLoad),
        .cnt_load_val (cntLoadVal),
        .busy         (busy),
        .done         (done),
        .period_cnt   (periodCnt)
`ifdef COUNTER_SEQUENCER_IRQ_EN
        ,
        .irq_clr      (irqClr),
        .irq          (irq)
`endif
    );

    // Free-running clock and a cycle index counting rising edges.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural counter: synchronous reset, load has priority over enable.
    always @(posedge clk) begin
        if (rst) begin
            cntValue <= '0;
        end else if (cntLoad) begin
            cntValue <= cntLoadVal;
        end else if (cntEn) begin
            cntValue <= cntValue + 8'd1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) tick();
    endtask

    // Present one command for a single cycle; returns 1 time unit after the
    // edge that accepted it.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] arg);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdArg   = arg;
        tick();
        cmdValid = 1'b0;
        cmdOp    = OP_NOP;
        cmdArg   = '0;
    endtask

    task automatic pushExp(input int cycle, input logic [W-1:0] value,
                           input logic [PCNT_W-1:0] pcnt);
        expEntry_t e;
        e.cycle = cycle;
        e.value = value;
        e.pcnt  = pcnt;
        expQ.push_back(e);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        expEntry_t e;
        if (!rst && done) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: got done=1 expected none (cycle %0d, cnt=%0d)",
                         cyc, cntValue);
            end else begin
                e = expQ.pop_front();
                checkOutput("done_cycle", cyc, e.cycle);
                checkOutput("done_value", cntValue, e.value);
                checkOutput("done_pcnt", periodCnt, e.pcnt);
            end
        end
    end

    // Global time bound so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        rst      = 1'b1;
        cmdValid = 1'b0;
        cmdOp    = OP_NOP;
        cmdArg   = '0;
`ifdef COUNTER_SEQUENCER_IRQ_EN
        irqClr   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkOutput("rst_ready", cmdReady, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_en", cntEn, 0);
        checkOutput("rst_load", cntLoad, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pcnt", periodCnt, 0);
        checkOutput("rst_loadval", cntLoadVal, 0);
`ifdef COUNTER_SEQUENCER_IRQ_EN
        checkOutput("rst_irq", irq, 0);
`endif

        // One-shot 5 -> 9
        applyStimulus(OP_LOAD, 8'd5);
        applyStimulus(OP_SET_TERM, 8'd9);
        applyStimulus(OP_START_ONESHOT, 8'd0);
        c = cyc;
        pushExp(c + 5, 8'd9, 8'd0);
        checkOutput("arm_ready", cmdReady, 0);
        checkOutput("arm_load", cntLoad, 1);
        checkOutput("arm_loadval", cntLoadVal, 5);
        checkOutput("arm_busy", busy, 1);
        tick();
        checkOutput("run_first_val", cntValue, 5);
        checkOutput("run_en", cntEn, 1);
        waitCycle(c + 5);
        checkOutput("oneshot_match_en", cntEn, 0);
        waitCycle(c + 8);
        checkOutput("oneshot_busy", busy, 0);
        checkOutput("oneshot_hold", cntValue, 9);
        checkOutput("oneshot_en", cntEn, 0);
        checkOutput("oneshot_pcnt", periodCnt, 1);
`ifdef COUNTER_SEQUENCER_IRQ_EN
        checkOutput("irq_set", irq, 1);
        irqClr = 1'b1;
        tick();
        irqClr = 1'b0;
        checkOutput("irq_clr", irq, 0);
`endif

        // Periodic 250 -> 3 with wrap, 10-cycle windows, STOP in match cycle
        applyStimulus(OP_LOAD, 8'd250);
        applyStimulus(OP_SET_TERM, 8'd3);
        applyStimulus(OP_START_PERIODIC, 8'd0);
        c = cyc;
        pushExp(c + 10, 8'd3, 8'd0);
        pushExp(c + 20, 8'd3, 8'd1);
        pushExp(c + 30, 8'd3, 8'd2);
        pushExp(c + 40, 8'd3, 8'd3);
        checkOutput("periodic_pcnt_clear", periodCnt, 0);
        waitCycle(c + 7);
        checkOutput("periodic_wrap", cntValue, 0);
        waitCycle(c + 10);
        checkOutput("periodic_reload", cntLoad, 1);
        checkOutput("periodic_match_en", cntEn, 0);
`ifdef COUNTER_SEQUENCER_IRQ_EN
        irqClr = 1'b1;
`endif
        tick();
`ifdef COUNTER_SEQUENCER_IRQ_EN
        irqClr = 1'b0;
        checkOutput("irq_set_wins", irq, 1);
`endif
        checkOutput("periodic_restart_val", cntValue, 250);
        checkOutput("periodic_pcnt1", periodCnt, 1);
        checkOutput("periodic_busy", busy, 1);
        waitCycle(c + 40);
        checkOutput("stop_match_done", done, 1);
        checkOutput("stop_match_load", cntLoad, 1);
        applyStimulus(OP_STOP, 8'd0);
        checkOutput("stop_busy", busy, 0);
        checkOutput("stop_pcnt", periodCnt, 4);
        checkOutput("stop_en", cntEn, 0);
        checkOutput("stop_ready", cmdReady, 1);

        // Pause at 7 for 4 cycles, then resume; done is delayed by 4 cycles
        applyStimulus(OP_LOAD, 8'd3);
        applyStimulus(OP_SET_TERM, 8'd12);
        applyStimulus(OP_START_ONESHOT, 8'd0);
        c = cyc;
        pushExp(c + 14, 8'd12, 8'd0);
        waitCycle(c + 4);
        checkOutput("pre_pause_val", cntValue, 6);
        applyStimulus(OP_PAUSE, 8'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("pause_hold", cntValue, 7);
            checkOutput("pause_en", cntEn, 0);
            if (i < 3) tick();
        end
        checkOutput("pause_busy", busy, 1);
        applyStimulus(OP_RESUME, 8'd0);
        checkOutput("resume_val", cntValue, 7);
        checkOutput("resume_en", cntEn, 1);
        tick();
        checkOutput("resume_next", cntValue, 8);
        waitCycle(c + 16);
        checkOutput("pause_final_val", cntValue, 12);
        checkOutput("pause_final_busy", busy, 0);
        checkOutput("pause_final_pcnt", periodCnt, 1);

        // START held through ARM, then reset during RUN
        applyStimulus(OP_LOAD, 8'd20);
        applyStimulus(OP_SET_TERM, 8'd100);
        cmdValid = 1'b1;
        cmdOp    = OP_START_ONESHOT;
        tick();
        checkOutput("hold_arm_ready", cmdReady, 0);
        checkOutput("hold_arm_loadval", cntLoadVal, 20);
        tick();
        checkOutput("hold_run_ready", cmdReady, 1);
        checkOutput("hold_run_val", cntValue, 20);
        tick();
        cmdValid = 1'b0;
        cmdOp    = OP_NOP;
        checkOutput("hold_ignored_load", cntLoad, 0);
        checkOutput("hold_ignored_en", cntEn, 1);
        checkOutput("hold_ignored_val", cntValue, 21);
        rst = 1'b1;
        tick();
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_en", cntEn, 0);
        checkOutput("midrst_load", cntLoad, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_loadval", cntLoadVal, 0);
        checkOutput("midrst_ready", cmdReady, 1);
        checkOutput("midrst_cnt", cntValue, 0);
        rst = 1'b0;

        // After reset term is all-ones: window 0..255
        applyStimulus(OP_START_ONESHOT, 8'd0);
        c = cyc;
        pushExp(c + 256, 8'd255, 8'd0);
        waitCycle(c + 258);
        checkOutput("termrst_busy", busy, 0);
        checkOutput("termrst_val", cntValue, 255);
        checkOutput("termrst_pcnt", periodCnt, 1);

        repeat (3) tick();
        checkOutput("sb_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
